// File: rtl/am2940_pkg.sv
// Shared types and helpers for the AM2940 DMA address generator slice.
// The instruction and mode encodings match the bus-level opcode values.
package am2940_pkg;

  localparam int WC_WIDTH = 8;

  typedef enum logic [2:0] {
    INSTR_NOP     = 3'd0,
    INSTR_WR_CTRL = 3'd1,
    INSTR_WR_WCR  = 3'd2,
    INSTR_RD_WC   = 3'd3,
    INSTR_RD_WCR  = 3'd4,
    INSTR_REINIT  = 3'd5,
    INSTR_LOAD_WC = 3'd6,
    INSTR_RD_CTRL = 3'd7
  } instr_e;

  typedef enum logic [1:0] {
    WC_DOWN    = 2'd0,
    WC_CMP     = 2'd1,
    ADDR_CMP   = 2'd2,
    COUNT_ONLY = 2'd3
  } mode_e;

  // Instructions that overwrite the word counter and therefore block a count.
  function automatic logic writes_wc(input instr_e op);
    return (op == INSTR_WR_WCR) || (op == INSTR_REINIT) || (op == INSTR_LOAD_WC);
  endfunction

  function automatic logic is_read(input instr_e op);
    return (op == INSTR_RD_WC) || (op == INSTR_RD_WCR) || (op == INSTR_RD_CTRL);
  endfunction

  function automatic logic clears_done(input instr_e op);
    return (op == INSTR_WR_WCR) || (op == INSTR_REINIT);
  endfunction

endpackage

// File: rtl/word_count_unit_wc_counter.sv
// Loadable W-bit up/down word counter; a load always takes priority over a count.
module wc_counter
  import am2940_pkg::*;
#(
  parameter int W = WC_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  input  logic         up_i,
  output logic [W-1:0] value_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Arithmetic wraps modulo 2^W with no carry or borrow indication.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (count_i) begin
      value_d = up_i ? (value_q + ONE) : (value_q - ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/word_count_unit.sv
// Word-count stage of the AM2940: mode register, WCR, word counter and
// sticky done flag, with instruction decode and the registered read port.
module word_count_unit
  import am2940_pkg::*;
#(
  parameter int W = WC_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   instr,
  input  logic         instr_vld,
  input  logic [W-1:0] data_in,
  input  logic         cnt_en,
  input  logic         done_in,
  output logic [W-1:0] dowc,
  output logic [W-1:0] dowr,
  output logic [1:0]   mode,
  output logic         cinw,
  output logic [W-1:0] data_out,
  output logic         data_oe,
  output logic         done_flag
);

  mode_e        mode_q;
  mode_e        mode_d;
  logic [W-1:0] dowr_q;
  logic [W-1:0] dowr_d;
  logic         done_q;
  logic         done_d;
  logic [W-1:0] dataOut_q;
  logic [W-1:0] dataOut_d;
  logic         dataOe_q;
  logic         dataOe_d;

  instr_e       instrOp;
  logic         wcWrite;
  logic         countAccept;
  logic [W-1:0] loadVal;
  logic [W-1:0] ctrlWord;
  logic [W-1:0] wcValue;

  assign instrOp     = instr_e'(instr);
  assign cinw        = cnt_en & ~done_q;
  assign wcWrite     = instr_vld & writes_wc(instrOp);
  assign countAccept = cinw & ~wcWrite;

  always_comb begin
    ctrlWord      = '0;
    ctrlWord[2:0] = {done_q, mode_q};
  end

  // Counter load value; outside mode 0 the counter restarts from zero.
  always_comb begin
    loadVal = '0;
    if (instr_vld) begin
      case (instrOp)
        INSTR_WR_WCR:  loadVal = (mode_q == WC_DOWN) ? data_in : '0;
        INSTR_REINIT:  loadVal = (mode_q == WC_DOWN) ? dowr_q  : '0;
        INSTR_LOAD_WC: loadVal = data_in;
        default:       loadVal = '0;
      endcase
    end
  end

  wc_counter #(
    .W (W)
  ) u_wc_counter (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (wcWrite),
    .load_val_i (loadVal),
    .count_i    (countAccept),
    .up_i       (mode_q != WC_DOWN),
    .value_o    (wcValue)
  );

  always_comb begin
    mode_d    = mode_q;
    dowr_d    = dowr_q;
    done_d    = done_q;
    dataOut_d = dataOut_q;
    dataOe_d  = instr_vld & is_read(instrOp);
    if (instr_vld) begin
      case (instrOp)
        INSTR_WR_CTRL: mode_d    = mode_e'(data_in[1:0]);
        INSTR_WR_WCR:  dowr_d    = data_in;
        INSTR_RD_WC:   dataOut_d = wcValue;
        INSTR_RD_WCR:  dataOut_d = dowr_q;
        INSTR_RD_CTRL: dataOut_d = ctrlWord;
        default:       dataOut_d = dataOut_q;
      endcase
      if (clears_done(instrOp)) begin
        done_d = 1'b0;
      end
    end
    // A count never coincides with a clear, since both clears also write the counter.
    if (countAccept && done_in) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= WC_DOWN;
      dowr_q    <= '0;
      done_q    <= 1'b0;
      dataOut_q <= '0;
      dataOe_q  <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      dowr_q    <= dowr_d;
      done_q    <= done_d;
      dataOut_q <= dataOut_d;
      dataOe_q  <= dataOe_d;
    end
  end

  assign dowc      = wcValue;
  assign dowr      = dowr_q;
  assign mode      = mode_q;
  assign done_flag = done_q;
  assign data_out  = dataOut_q;
  assign data_oe   = dataOe_q;

endmodule

// File: tb/tb_word_count_unit.sv
// Scoreboard bench for word_count_unit with a bench-side done-generator model.
module tb_word_count_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] instr;
  logic       instr_vld;
  logic [7:0] data_in;
  logic       cnt_en;
  logic       done_in;
  logic [7:0] dowc;
  logic [7:0] dowr;
  logic [1:0] mode;
  logic       cinw;
  logic [7:0] data_out;
  logic       data_oe;
  logic       done_flag;

  typedef struct packed {
    logic [7:0] wc;
    logic [7:0] wr;
    logic [1:0] md;
    logic       dn;
    logic       oe;
    logic [7:0] dout;
    logic       cw;
  } obs_t;

  typedef struct packed {
    logic [2:0] ins;
    logic       vld;
    logic [7:0] d;
    logic       cnt;
  } step_t;

  obs_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  logic [7:0] mWc, mWr, mDout;
  logic [1:0] mMode;
  logic       mDone, mOe;

  word_count_unit #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .instr_vld (instr_vld),
    .data_in   (data_in),
    .cnt_en    (cnt_en),
    .done_in   (done_in),
    .dowc      (dowc),
    .dowr      (dowr),
    .mode      (mode),
    .cinw      (cinw),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .done_flag (done_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t st(input logic [2:0] ins, input logic vld,
                               input logic [7:0] d, input logic cnt);
    st = '{ins: ins, vld: vld, d: d, cnt: cnt};
  endfunction

  function automatic obs_t sample();
    sample = {dowc, dowr, mode, done_flag, data_oe, data_out, cinw};
  endfunction

  task automatic model_reset();
    mWc = '0; mWr = '0; mMode = '0; mDone = 1'b0; mOe = 1'b0; mDout = '0;
    sbq.delete();
  endtask

  // Drives one cycle, advances the reference model and pushes its expectation.
  task automatic drive(input step_t s);
    obs_t       e;
    logic       dIn, cw, wcw, acc;
    logic [7:0] nWc, nWr, nDout;
    logic [1:0] nMode;
    logic       nDone, nOe;
    @(negedge clk);
    dIn = (mMode == 2'd0) ? (mWc == 8'd1) :
          (mMode == 2'd1) ? (mWc == mWr - 8'd1) : 1'b0;
    instr = s.ins; instr_vld = s.vld; data_in = s.d; cnt_en = s.cnt; done_in = dIn;
    cw  = s.cnt & ~mDone;
    wcw = s.vld && (s.ins == 3'd2 || s.ins == 3'd5 || s.ins == 3'd6);
    acc = cw & ~wcw;
    nWc = mWc; nWr = mWr; nMode = mMode; nDone = mDone; nDout = mDout; nOe = 1'b0;
    if (s.vld) begin
      case (s.ins)
        3'd1: nMode = s.d[1:0];
        3'd2: begin nWr = s.d; nWc = (mMode == 2'd0) ? s.d : 8'h00; nDone = 1'b0; end
        3'd3: begin nDout = mWc; nOe = 1'b1; end
        3'd4: begin nDout = mWr; nOe = 1'b1; end
        3'd5: begin nWc = (mMode == 2'd0) ? mWr : 8'h00; nDone = 1'b0; end
        3'd6: nWc = s.d;
        3'd7: begin nDout = {5'b0, mDone, mMode}; nOe = 1'b1; end
        default: ;
      endcase
    end
    if (acc) begin
      nWc = (mMode == 2'd0) ? mWc - 8'd1 : mWc + 8'd1;
      if (dIn) nDone = 1'b1;
    end
    mWc = nWc; mWr = nWr; mMode = nMode; mDone = nDone; mDout = nDout; mOe = nOe;
    e = '{wc: nWc, wr: nWr, md: nMode, dn: nDone, oe: nOe, dout: nDout, cw: s.cnt & ~nDone};
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t steps[$];
    obs_t  e, o;
    steps = '{st(3'd1, 1'b1, 8'h00, 1'b0), st(3'd2, 1'b1, 8'h05, 1'b0),
              st(3'd0, 1'b0, 8'h00, 1'b1), st(3'd0, 1'b0, 8'h00, 1'b1)};
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL reset_pre[%0d]: got %h expected %h", i, o, e); end
    end
    #2;
    rst_n = 1'b0; cnt_en = 1'b0; instr_vld = 1'b0; done_in = 1'b0;
    #1;
    o = sample(); nChecks++;
    if (o !== obs_t'(0)) begin nFails++; $display("[TB] FAIL reset_async: got %h expected %h", o, obs_t'(0)); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    steps = '{st(3'd7, 1'b1, 8'h00, 1'b0), st(3'd0, 1'b0, 8'h00, 1'b0)};
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL reset_rdctrl[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_mode0_countdown();
    step_t steps[$];
    obs_t  e, o;
    steps = '{st(3'd1, 1'b1, 8'h00, 1'b0), st(3'd2, 1'b1, 8'h03, 1'b0)};
    for (int k = 0; k < 13; k++) steps.push_back(st(3'd0, 1'b0, 8'h00, 1'b1));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL mode0[%0d]: got %h expected %h", i, o, e); end
    end
    nChecks++;
    if (dowc !== 8'h00 || done_flag !== 1'b1 || cinw !== 1'b0) begin
      nFails++; $display("[TB] FAIL mode0_end: got wc=%h done=%b cinw=%b expected 00 1 0", dowc, done_flag, cinw);
    end
  endtask

  task automatic test_mode1_compare();
    step_t steps[$];
    obs_t  e, o;
    steps = '{st(3'd1, 1'b1, 8'h01, 1'b1), st(3'd2, 1'b1, 8'h04, 1'b0)};
    for (int k = 0; k < 6; k++) steps.push_back(st(3'd0, 1'b0, 8'h00, 1'b1));
    steps.push_back(st(3'd5, 1'b1, 8'h00, 1'b1));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL mode1[%0d]: got %h expected %h", i, o, e); end
    end
    nChecks++;
    if (dowc !== 8'h00 || done_flag !== 1'b0) begin
      nFails++; $display("[TB] FAIL mode1_reinit: got wc=%h done=%b expected 00 0", dowc, done_flag);
    end
  endtask

  task automatic test_wrap();
    step_t steps[$];
    obs_t  e, o;
    steps = '{st(3'd1, 1'b1, 8'h03, 1'b0), st(3'd6, 1'b1, 8'hFF, 1'b0),
              st(3'd0, 1'b0, 8'h00, 1'b1), st(3'd1, 1'b1, 8'h00, 1'b0),
              st(3'd6, 1'b1, 8'h00, 1'b0), st(3'd0, 1'b0, 8'h00, 1'b1),
              st(3'd0, 1'b0, 8'h00, 1'b0)};
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL wrap[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_collision();
    step_t steps[$];
    obs_t  e, o;
    steps = '{st(3'd1, 1'b1, 8'h02, 1'b0), st(3'd6, 1'b1, 8'h5A, 1'b1),
              st(3'd0, 1'b0, 8'h00, 1'b0)};
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL collision[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    step_t steps[$];
    obs_t  e, o;
    steps = '{st(3'd1, 1'b1, 8'h01, 1'b0), st(3'd2, 1'b1, 8'h20, 1'b0),
              st(3'd0, 1'b0, 8'h00, 1'b1), st(3'd3, 1'b1, 8'h00, 1'b1),
              st(3'd4, 1'b1, 8'h00, 1'b1), st(3'd7, 1'b1, 8'h00, 1'b1),
              st(3'd0, 1'b0, 8'h00, 1'b1), st(3'd0, 1'b0, 8'h00, 1'b0)};
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    for (int i = 0; i < 200; i++) begin
      drive(st(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0)));
      e = sbq.pop_front(); o = sample(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL random[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_vld = 1'b0; data_in = '0; cnt_en = 1'b0; done_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] starting word_count_unit tests");
    test_reset();
    test_mode0_countdown();
    test_mode1_compare();
    test_wrap();
    test_collision();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/word_count_unit.md
# word_count_unit

Word-count stage of the AM2940 DMA address generator, directly upstream of the done generator. Holds the control (mode) register, the 8-bit word count register (WCR) and the 8-bit word counter (WC), and decodes the word-count-related instructions from the data/instruction bus. Drives `dowc`, `dowr`, `mode` and the qualified count-enable `cinw` into the done generator. Consumes that block's `done` output to stop counting once a transfer block completes.

## Interface

Parameters:
- `W`, default 8: data, counter and register width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  3  instruction code, sampled when `instr_vld`=1.
- `instr_vld`  in  1  instruction strobe, one cycle per instruction.
- `data_in`  in  W  write data for the register-load instructions.
- `cnt_en`  in  1  request to count one word this cycle.
- `done_in`  in  1  combinational `done` from the done generator.
- `dowc`  out  W  word counter value.
- `dowr`  out  W  word count register value.
- `mode`  out  2  current mode.
- `cinw`  out  1  `cnt_en & ~done_flag`, a qualified count enable.
- `data_out`  out  W  registered read data.
- `data_oe`  out  1  high for one cycle when `data_out` is valid.
- `done_flag`  out  1  sticky block-complete flag.

## Operation

Instructions take effect only when `instr_vld`=1:
- 0 NOP.
- 1 WR_CTRL: `mode` <= `data_in[1:0]`.
- 2 WR_WCR: `dowr` <= `data_in`. In the same cycle, `dowc` <= `data_in` if the current `mode` is 0, else `dowc` <= 0. Clears `done_flag`.
- 3 RD_WC: `data_out` <= `dowc`.
- 4 RD_WCR: `data_out` <= `dowr`.
- 5 REINIT: `dowc` <= (`mode`==0 ? `dowr` : 0). Clears `done_flag`.
- 6 LOAD_WC: `dowc` <= `data_in`. Does not touch `done_flag`.
- 7 RD_CTRL: `data_out` <= {0…, `done_flag`, `mode`}, zero-extended to W.

Read instructions (3, 4, 7) set `data_oe`=1 for exactly the following cycle. Otherwise `data_oe`=0, and `data_out` holds its last value.

Counting:
- A count is accepted when `cinw`=1 and no instruction that writes `dowc` (2, 5, 6) is active in that cycle. A write to `dowc` always wins over a count; the count is dropped, not deferred.
- Mode 0: `dowc` decrements. Modes 1, 2 and 3: `dowc` increments.
- Arithmetic is modulo 2^W and wraps silently: 0-1 gives FF, FF+1 gives 00.

Done handling:
- When a count is accepted while `done_in`=1, the count is still performed and `done_flag` is set on the same edge.
- While `done_flag`=1, `cinw`=0, so no further counts occur.
- `done_flag` is cleared only by WR_WCR, REINIT or reset.
- In mode 3 the done generator never asserts `done_in`, so `done_flag` stays 0 unless it was already set.
- WR_CTRL does not clear `done_flag`.

Reset (asynchronous, `rst_n`=0): `dowc`=0, `dowr`=0, `mode`=0, `done_flag`=0, `data_out`=0, `data_oe`=0. `cinw` is therefore 0 whenever `cnt_en`=0. Reset asserted mid-block abandons the count with no partial state.

## Timing

- All state updates on the rising edge of `clk`; there is no multicycle path.
- Write instructions: the new value is visible on outputs one cycle after the `instr_vld` cycle.
- Read instructions: `data_out` and `data_oe` are valid the next cycle. Read data is the value before any count accepted in the same cycle.
- Count: `dowc` updates one cycle after acceptance.
- `done_in` is sampled in the same cycle as the count it qualifies. The loop path `dowc` -> done generator -> `done_in` -> `done_flag` must close in one cycle.
- `cinw` is combinational from `cnt_en` and the registered `done_flag`.
- Back-to-back instructions and counts are allowed every cycle.

## Structure

Shared package `am2940_pkg` holds:
- the instruction enum `instr_e` (values 0–7 as above);
- the mode enum `mode_e` (WC_DOWN=0, WC_CMP=1, ADDR_CMP=2, COUNT_ONLY=3);
- the default width constant.

A single sub-module is natural: `wc_counter`, the W-bit up/down loadable counter with load-priority-over-count. Instruction decode, the registers, the done flag and the read mux stay in the top level. `done_gen` is instantiated by the parent, not inside this block.

## Test plan

- Reset: hold `rst_n`=0 mid-count -> all outputs 0 immediately. After release, RD_CTRL returns 00 with `data_oe` high for 1 cycle.
- Mode 0, WR_WCR 03, `cnt_en` held high, `done_in` driven by the done-generator model -> `dowc` goes 03, 02, 01. The count at 01 sets `done_flag`, and `dowc` reaches 00. `cinw` then drops, and `dowc` holds at 00 for 10 more cycles.
- Mode 1, WR_WCR 04 (`dowc` becomes 00), count -> `dowc` steps 00…04 with done at the correct step. REINIT -> `dowc`=00 and `done_flag`=0.
- Wrap: LOAD_WC FF in mode 3, one count -> `dowc`=00 and `done_flag` stays 0. Mode 0 with LOAD_WC 00, one count -> `dowc`=FF.
- Collision: `cnt_en`=1 in the same cycle as LOAD_WC 5A -> `dowc`=5A next cycle, with no increment applied.
- Reads: RD_WC, RD_WCR and RD_CTRL issued back-to-back while counting -> three consecutive `data_oe` pulses, each carrying the pre-count value from its own cycle.
